// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between core and data-memory responder
interface data_mem_responder_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_wr;
    logic [N-1:0] req_addr;
    logic [2:0]   req_funct3;
    logic [N-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle byte/half/word data-memory responder with wait states
// Optional misalignment faulting: PHILV_DMEM_MISALIGN_CHECK_EN
module data_mem_responder #(
    parameter int          N           = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rstb,
    data_mem_responder_if.slave bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         wr_q;
    logic [N-1:0] addr_q, wdata_q;
    logic [2:0]   funct3_q;
    logic [N-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [N-1:0] mem [DEPTH_WORDS];

    logic         accept, commit, we;
    logic         a_wr;
    logic [N-1:0] a_addr, a_wdata;
    logic [2:0]   a_f3;
    logic [N-1:0] offset, word, wr_word, load_data;
    logic [AW-1:0] idx;
    logic [1:0]   lane;
    logic [7:0]   sel_b;
    logic [15:0]  sel_h;
    logic         misalign, bad_f3, fault;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        accept  = (state_q == IDLE) && bus.req_valid;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so use the live request.
    always_comb begin
        a_wr    = wr_q;
        a_addr  = addr_q;
        a_f3    = funct3_q;
        a_wdata = wdata_q;
        if (state_q == IDLE) begin
            a_wr    = bus.req_wr;
            a_addr  = bus.req_addr;
            a_f3    = bus.req_funct3;
            a_wdata = bus.req_wdata;
        end
        offset = a_addr - BASE_ADDR;
        idx    = offset[AW+1:2];
        lane   = a_addr[1:0];
        word   = mem[idx];
        sel_b  = word[{lane, 3'b000} +: 8];
        sel_h  = lane[1] ? word[31:16] : word[15:0];
`ifdef PHILV_DMEM_MISALIGN_CHECK_EN
        misalign = ((a_f3[1:0] == 2'b01) && lane[0]) || ((a_f3[1:0] == 2'b10) && (lane != 2'b00));
`else
        misalign = 1'b0;
`endif
        bad_f3 = a_wr ? (a_f3[2] || (a_f3[1:0] == 2'b11))
                      : ((a_f3[1:0] == 2'b11) || (a_f3 == 3'b110));
        fault  = ({1'b0, offset} >= LIMIT) || bad_f3 || misalign;

        wr_word = word;
        case (a_f3[1:0])
            2'b00:   wr_word[{lane, 3'b000} +: 8] = a_wdata[7:0];
            2'b01: begin
                if (lane[1]) wr_word[31:16] = a_wdata[15:0];
                else         wr_word[15:0]  = a_wdata[15:0];
            end
            2'b10:   wr_word = a_wdata;
            default: wr_word = word;
        endcase

        case (a_f3)
            3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
            3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'd0, sel_b};
            3'b101:  load_data = {16'd0, sel_h};
            default: load_data = '0;
        endcase

        rdata_d = (fault || a_wr) ? '0 : load_data;
        err_d   = fault;
        we      = commit && a_wr && !fault && rstb;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            funct3_q <= 3'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q     <= bus.req_wr;
                addr_q   <= bus.req_addr;
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wr_word;
    end
endmodule
